// File: rtl/ddr_read_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module : ddr_read_dispatch_if
// Desc   : Instruction, receive-forward and dual DDR descriptor bus bundle for
//          the ddr2pe read dispatcher.
// Rev    : 1.0 - initial release
// ============================================================================
interface ddr_read_dispatch_if #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16,
    parameter int INST_W     = 64
);
    logic [7:0]            in_img_width;
    logic [7:0]            out_img_width;
    logic [3:0]            in_ch_seg;
    logic [3:0]            out_ch_seg;

    logic                  ins_valid;
    logic                  ins_ready;
    logic [INST_W-1:0]     ins;

    logic                  rx_ins_valid;
    logic                  rx_ins_ready;
    logic [INST_W-1:0]     rx_ins;

    logic                  ddr1_conf_valid;
    logic                  ddr1_conf_ready;
    logic [DDR_ADDR_W-1:0] ddr1_st_addr;
    logic [BURST_W-1:0]    ddr1_burst;
    logic [DDR_ADDR_W-1:0] ddr1_step;
    logic [BURST_W-1:0]    ddr1_burst_num;
    logic                  ddr1_done;

    logic                  ddr2_conf_valid;
    logic                  ddr2_conf_ready;
    logic [DDR_ADDR_W-1:0] ddr2_st_addr;
    logic [BURST_W-1:0]    ddr2_burst;
    logic [DDR_ADDR_W-1:0] ddr2_step;
    logic [BURST_W-1:0]    ddr2_burst_num;
    logic                  ddr2_done;

    // The dispatcher itself.
    modport slave (
        input  in_img_width, out_img_width, in_ch_seg, out_ch_seg,
        input  ins_valid, ins,
        output ins_ready,
        output rx_ins_valid, rx_ins,
        input  rx_ins_ready,
        output ddr1_conf_valid, ddr1_st_addr, ddr1_burst, ddr1_step, ddr1_burst_num,
        input  ddr1_conf_ready, ddr1_done,
        output ddr2_conf_valid, ddr2_st_addr, ddr2_burst, ddr2_step, ddr2_burst_num,
        input  ddr2_conf_ready, ddr2_done
    );

    // Scheduler, DDR read engines and data-receive module.
    modport master (
        output in_img_width, out_img_width, in_ch_seg, out_ch_seg,
        output ins_valid, ins,
        input  ins_ready,
        input  rx_ins_valid, rx_ins,
        output rx_ins_ready,
        input  ddr1_conf_valid, ddr1_st_addr, ddr1_burst, ddr1_step, ddr1_burst_num,
        output ddr1_conf_ready, ddr1_done,
        input  ddr2_conf_valid, ddr2_st_addr, ddr2_burst, ddr2_step, ddr2_burst_num,
        output ddr2_conf_ready, ddr2_done
    );
endinterface
`default_nettype wire

// File: rtl/ddr_read_dispatch.sv
`default_nettype none
// ============================================================================
// Module : ddr_read_dispatch
// Desc   : Queued DDR read-configuration dispatcher; decodes each instruction
//          into a burst descriptor for DDR read channel 1 or 2, forwards it to
//          the receive side and retires it on channel completion.
//          Optional macro DDR_RD_STAT_EN adds the stat_retired counter.
// Rev    : 1.0 - initial release
// ============================================================================
module ddr_read_dispatch #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16,
    parameter int INST_W     = 64,
    parameter int TD_RATE    = 4,
    parameter int Q_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DDR_RD_STAT_EN
    output logic [15:0] stat_retired,
`endif
    ddr_read_dispatch_if.slave bus
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_1    = 2'd1;
    localparam logic [1:0] CH_2    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [INST_W-1:0] mem_q [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ins_ready_q, ins_ready_d;
    logic              w_push;
    logic              w_pop;
    logic [INST_W-1:0] w_head;

    assign w_push        = bus.ins_valid && ins_ready_q;
    assign w_head        = mem_q[rd_ptr_q];
    assign bus.ins_ready = ins_ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Readiness comes from the registered count, so a full queue never
        // accepts even when it pops in the same cycle.
        ins_ready_d = (count_d < CNT_W'(Q_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= bus.ins;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ins_ready_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ins_ready_q <= ins_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the queue head
    // ------------------------------------------------------------------
    logic [3:0]            w_op;
    logic [4:0]            w_pix1;
    logic [8:0]            w_size1;
    logic [8:0]            w_in_burst_p, w_out_burst_p;
    logic [12:0]           w_in_step_p, w_out_step_p;
    logic [43:0]           w_td_p;
    logic [1:0]            w_tgt;
    logic [BURST_W-1:0]    w_burst;
    logic [DDR_ADDR_W-1:0] w_step;
    logic [BURST_W-1:0]    w_bnum;
    logic [DDR_ADDR_W-1:0] w_addr;
    logic                  w_unused_bits;

    assign w_op          = w_head[61:58];
    assign w_pix1        = {1'b0, w_head[43:40]} + 5'd1;
    assign w_size1       = {1'b0, w_head[39:32]} + 9'd1;
    assign w_in_burst_p  = 9'(w_pix1) * 9'(bus.in_ch_seg);
    assign w_out_burst_p = 9'(w_pix1) * 9'(bus.out_ch_seg);
    assign w_in_step_p   = 13'(w_pix1) * 13'(bus.in_img_width);
    assign w_out_step_p  = 13'(w_pix1) * 13'(bus.out_img_width);
    assign w_td_p        = 44'(w_head[51:40]) * 44'(TD_RATE);
    assign w_addr        = DDR_ADDR_W'(w_head[31:0]);
    assign w_unused_bits = ^{w_head[INST_W-1:62], w_head[57:52]};

    // 0100 and 0111 are carved out of their opcode groups, so test them first.
    always_comb begin
        w_tgt   = CH_NONE;
        w_burst = '0;
        w_step  = '0;
        w_bnum  = '0;
        if (w_op == 4'b0100) begin
            w_tgt   = CH_1;
            w_burst = BURST_W'(w_size1);
        end else if (w_op == 4'b0111) begin
            w_tgt   = CH_2;
            w_burst = BURST_W'({w_out_burst_p, 5'b0});
            w_step  = DDR_ADDR_W'({w_out_step_p, 5'b0});
            w_bnum  = BURST_W'(w_head[47:44]);
        end else if (w_op[3:2] == 2'b00) begin
            w_tgt   = CH_1;
            w_burst = BURST_W'({w_in_burst_p, 5'b0});
            w_step  = DDR_ADDR_W'({w_in_step_p, 5'b0});
            w_bnum  = BURST_W'(w_head[47:44]);
        end else if (w_op[3:2] == 2'b01) begin
            w_tgt   = CH_2;
            w_burst = w_op[1] ? BURST_W'(w_td_p) : BURST_W'(w_head[51:40]);
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM and registered outputs
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [1:0]            tgt_q, tgt_d;
    logic                  c1_valid_q, c1_valid_d;
    logic                  c2_valid_q, c2_valid_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [INST_W-1:0]     rx_ins_q, rx_ins_d;
    logic [DDR_ADDR_W-1:0] d1_addr_q, d1_addr_d, d2_addr_q, d2_addr_d;
    logic [BURST_W-1:0]    d1_burst_q, d1_burst_d, d2_burst_q, d2_burst_d;
    logic [DDR_ADDR_W-1:0] d1_step_q, d1_step_d, d2_step_q, d2_step_d;
    logic [BURST_W-1:0]    d1_num_q, d1_num_d, d2_num_q, d2_num_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tgt_q      <= CH_NONE;
            c1_valid_q <= 1'b0;
            c2_valid_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ins_q   <= '0;
            d1_addr_q  <= '0;
            d1_burst_q <= '0;
            d1_step_q  <= '0;
            d1_num_q   <= '0;
            d2_addr_q  <= '0;
            d2_burst_q <= '0;
            d2_step_q  <= '0;
            d2_num_q   <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            c1_valid_q <= c1_valid_d;
            c2_valid_q <= c2_valid_d;
            rx_valid_q <= rx_valid_d;
            rx_ins_q   <= rx_ins_d;
            d1_addr_q  <= d1_addr_d;
            d1_burst_q <= d1_burst_d;
            d1_step_q  <= d1_step_d;
            d1_num_q   <= d1_num_d;
            d2_addr_q  <= d2_addr_d;
            d2_burst_q <= d2_burst_d;
            d2_step_q  <= d2_step_d;
            d2_num_q   <= d2_num_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        c1_valid_d = c1_valid_q;
        c2_valid_d = c2_valid_q;
        rx_valid_d = rx_valid_q;
        rx_ins_d   = rx_ins_q;
        d1_addr_d  = d1_addr_q;
        d1_burst_d = d1_burst_q;
        d1_step_d  = d1_step_q;
        d1_num_d   = d1_num_q;
        d2_addr_d  = d2_addr_q;
        d2_burst_d = d2_burst_q;
        d2_step_d  = d2_step_q;
        d2_num_d   = d2_num_q;
        w_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d    = ST_DISPATCH;
                    tgt_d      = w_tgt;
                    rx_ins_d   = w_head;
                    rx_valid_d = 1'b1;
                    // Only the target channel's descriptor is reloaded.
                    if (w_tgt == CH_1) begin
                        c1_valid_d = 1'b1;
                        d1_addr_d  = w_addr;
                        d1_burst_d = w_burst;
                        d1_step_d  = w_step;
                        d1_num_d   = w_bnum;
                    end else if (w_tgt == CH_2) begin
                        c2_valid_d = 1'b1;
                        d2_addr_d  = w_addr;
                        d2_burst_d = w_burst;
                        d2_step_d  = w_step;
                        d2_num_d   = w_bnum;
                    end
                end
            end
            ST_DISPATCH: begin
                if (c1_valid_q && bus.ddr1_conf_ready) c1_valid_d = 1'b0;
                if (c2_valid_q && bus.ddr2_conf_ready) c2_valid_d = 1'b0;
                if (rx_valid_q && bus.rx_ins_ready)    rx_valid_d = 1'b0;
                if (!c1_valid_d && !c2_valid_d && !rx_valid_d) begin
                    if (tgt_q == CH_NONE) begin
                        w_pop   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if ((tgt_q == CH_1 && bus.ddr1_done) || (tgt_q == CH_2 && bus.ddr2_done)) begin
                    w_pop   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rx_ins_valid    = rx_valid_q;
    assign bus.rx_ins          = rx_ins_q;
    assign bus.ddr1_conf_valid = c1_valid_q;
    assign bus.ddr1_st_addr    = d1_addr_q;
    assign bus.ddr1_burst      = d1_burst_q;
    assign bus.ddr1_step       = d1_step_q;
    assign bus.ddr1_burst_num  = d1_num_q;
    assign bus.ddr2_conf_valid = c2_valid_q;
    assign bus.ddr2_st_addr    = d2_addr_q;
    assign bus.ddr2_burst      = d2_burst_q;
    assign bus.ddr2_step       = d2_step_q;
    assign bus.ddr2_burst_num  = d2_num_q;

`ifdef DDR_RD_STAT_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (w_pop && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_retired = stat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_read_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr_read_dispatch
// Desc   : Self-checking bench for ddr_read_dispatch with a spec-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ddr_read_dispatch;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 16;
    localparam int INST_W     = 64;
    localparam int TD_RATE    = 4;
    localparam int Q_DEPTH    = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_retired = 0;
`ifdef DDR_RD_STAT_EN
    logic [15:0] stat_retired;
`endif

    ddr_read_dispatch_if #(.DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W), .INST_W(INST_W)) bus ();

    ddr_read_dispatch #(
        .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W), .INST_W(INST_W),
        .TD_RATE(TD_RATE), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef DDR_RD_STAT_EN
        .stat_retired(stat_retired),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [11:0] f,
                                       input logic [7:0] sz, input logic [31:0] a);
        return {2'b00, op, 6'b000000, f, sz, a};
    endfunction

    // Reference decode written straight from the opcode table.
    function automatic void model(input logic [63:0] w, output int ch,
                                  output logic [95:0] desc);
        int op, pix, row, sz, ps, burst, stp, num;
        op = int'(w[61:58]); pix = int'(w[43:40]); row = int'(w[47:44]);
        sz = int'(w[39:32]); ps = int'(w[51:40]);
        ch = 0; burst = 0; stp = 0; num = 0;
        if (op == 4) begin
            ch = 1; burst = sz + 1;
        end else if (op == 7) begin
            ch = 2; burst = (pix + 1) * int'(bus.out_ch_seg) * 32;
            stp = (pix + 1) * int'(bus.out_img_width) * 32; num = row;
        end else if (op < 4) begin
            ch = 1; burst = (pix + 1) * int'(bus.in_ch_seg) * 32;
            stp = (pix + 1) * int'(bus.in_img_width) * 32; num = row;
        end else if (op < 8) begin
            ch = 2; burst = (op == 6) ? ps * TD_RATE : ps;
        end
        desc = {w[31:0], 16'(burst), 32'(stp), 16'(num)};
    endfunction

    task automatic push(input logic [63:0] v, output bit ok);
        int n = 0;
        bus.ins = v;
        bus.ins_valid = 1'b1;
        while (!bus.ins_ready && n < 30) begin step(); n++; end
        ok = bus.ins_ready;
        if (ok) step();
        bus.ins_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!(bus.ddr1_conf_valid || bus.ddr2_conf_valid || bus.rx_ins_valid) && n < 20) begin
            step(); n++;
        end
        ok = bus.ddr1_conf_valid || bus.ddr2_conf_valid || bus.rx_ins_valid;
    endtask

    task automatic pulse_done(input int ch);
        bus.ddr1_done = (ch == 1);
        bus.ddr2_done = (ch == 2);
        step();
        bus.ddr1_done = 1'b0;
        bus.ddr2_done = 1'b0;
    endtask

    // Completes both handshakes, then retires through the target channel.
    task automatic serve(input int ch, input bit rnd, output bit ok, output bit bad_other,
                         output bit dropped);
        int n = 0;
        bit pc, pr, cv;
        ok = 1'b1; bad_other = 1'b0; dropped = 1'b0;
        while ((bus.ddr1_conf_valid || bus.ddr2_conf_valid || bus.rx_ins_valid) && n < 80) begin
            bus.ddr1_conf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ddr2_conf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rx_ins_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((ch != 1 && bus.ddr1_conf_valid) || (ch != 2 && bus.ddr2_conf_valid)) bad_other = 1'b1;
            cv = (ch == 1) ? bus.ddr1_conf_valid : (ch == 2) ? bus.ddr2_conf_valid : 1'b0;
            pc = cv && !((ch == 1) ? bus.ddr1_conf_ready : bus.ddr2_conf_ready);
            pr = bus.rx_ins_valid && !bus.rx_ins_ready;
            step(); n++;
            cv = (ch == 1) ? bus.ddr1_conf_valid : (ch == 2) ? bus.ddr2_conf_valid : 1'b0;
            if ((pc && !cv) || (pr && !bus.rx_ins_valid)) dropped = 1'b1;
        end
        if (n >= 80) ok = 1'b0;
        bus.ddr1_conf_ready = 1'b1;
        bus.ddr2_conf_ready = 1'b1;
        bus.rx_ins_ready    = 1'b1;
        if (ch != 0) begin
            if (rnd) repeat ($urandom_range(0, 2)) step();
            pulse_done(ch);
        end
        exp_retired++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (bus.ins_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ins_ready: got %b want 1", bus.ins_ready);
        end
        vectors++;
        if ({bus.ddr1_conf_valid, bus.ddr2_conf_valid, bus.rx_ins_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valids: got %b%b%b want 000", bus.ddr1_conf_valid,
                     bus.ddr2_conf_valid, bus.rx_ins_valid);
        end
        vectors++;
        if ({bus.ddr1_st_addr, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num,
             bus.ddr2_st_addr, bus.ddr2_burst, bus.ddr2_step, bus.ddr2_burst_num, bus.rx_ins} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: descriptor/rx_ins not zero, want 0");
        end
        rst = 1'b0;
        exp_retired = 0;
    endtask

    task automatic test_ch1_linear();
        logic [63:0] w;
        bit ok, bad, drop;
        w = mk(4'b0100, 12'h000, 8'd15, 32'h0000_1000);
        push(w, ok);
        vectors++;
        if (bus.ddr1_conf_valid !== 1'b0) begin
            miscompares++; $display("FAIL lat_early: ddr1_conf_valid got %b want 0", bus.ddr1_conf_valid);
        end
        step();
        vectors++;
        if ({ok, bus.ddr1_conf_valid, bus.rx_ins_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL lat_2cyc: accept/ddr1v/rxv got %b%b%b want 111", ok, bus.ddr1_conf_valid, bus.rx_ins_valid);
        end
        vectors++;
        if ({bus.ddr1_st_addr, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num} !== {32'h1000, 16'd16, 32'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL lin_desc: got addr=%h burst=%0d step=%0d num=%0d want 1000/16/0/0",
                     bus.ddr1_st_addr, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num);
        end
        vectors++;
        if (bus.rx_ins !== w) begin
            miscompares++; $display("FAIL lin_rx_ins: got %h want %h", bus.rx_ins, w);
        end
        serve(1, 1'b0, ok, bad, drop);
        vectors++;
        if ({ok, bad} !== 2'b10) begin
            miscompares++; $display("FAIL lin_serve: done/ddr2_stray got %b%b want 10", ok, bad);
        end
    endtask

    task automatic test_conv();
        bit ok, bad, drop;
        bus.in_ch_seg = 4'd2;
        bus.in_img_width = 8'd10;
        push(mk(4'b0000, {4'd0, 4'd5, 4'd3}, 8'd0, 32'h0000_2222), ok);
        wait_valid(ok);
        vectors++;
        if ({ok, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num} !== {1'b1, 16'd256, 32'd1280, 16'd5}) begin
            miscompares++;
            $display("FAIL conv_desc: got v=%b burst=%0d step=%0d num=%0d want 1/256/1280/5",
                     ok, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num);
        end
        serve(1, 1'b0, ok, bad, drop);
    endtask

    task automatic test_ch2();
        logic [3:0]  ops  [2] = '{4'b0110, 4'b0101};
        logic [15:0] exps [2] = '{16'd400, 16'd100};
        bit ok, bad, drop;
        for (int i = 0; i < 2; i++) begin
            push(mk(ops[i], 12'd100, 8'd0, 32'h0000_3000 + 32'(i)), ok);
            wait_valid(ok);
            vectors++;
            if ({bus.ddr2_conf_valid, bus.ddr1_conf_valid, bus.ddr2_burst, bus.ddr2_step} !== {2'b10, exps[i], 32'd0}) begin
                miscompares++;
                $display("FAIL ch2_desc op=%b: got v2=%b v1=%b burst=%0d step=%0d want 1/0/%0d/0",
                         ops[i], bus.ddr2_conf_valid, bus.ddr1_conf_valid, bus.ddr2_burst, bus.ddr2_step, exps[i]);
            end
            serve(2, 1'b0, ok, bad, drop);
        end
    endtask

    task automatic test_queue_full();
        logic [63:0] q [$];
        bit ok, all_ok, bad, drop, rdy_seen;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.push_back(mk(4'b0100, 12'h0, 8'(i), 32'h2000 + 32'(i * 16)));
            push(q[i], ok);
            all_ok &= ok;
        end
        vectors++;
        if ({all_ok, bus.ins_ready} !== 2'b10) begin
            miscompares++; $display("FAIL full_ready: accepted/ins_ready got %b%b want 10", all_ok, bus.ins_ready);
        end
        q.push_back(mk(4'b0100, 12'h0, 8'd4, 32'h2040));
        bus.ins = q[4];
        bus.ins_valid = 1'b1;
        rdy_seen = 1'b0;
        repeat (4) begin step(); rdy_seen |= bus.ins_ready; end
        vectors++;
        if ({rdy_seen, bus.ddr1_conf_valid, bus.ddr1_st_addr} !== {2'b00, 32'h2000}) begin
            miscompares++;
            $display("FAIL full_hold: ready_seen=%b ddr1v=%b addr=%h want 0/0/2000", rdy_seen,
                     bus.ddr1_conf_valid, bus.ddr1_st_addr);
        end
        pulse_done(1);
        exp_retired++;
        vectors++;
        if (bus.ins_ready !== 1'b1) begin
            miscompares++; $display("FAIL full_retire_ready: got %b want 1", bus.ins_ready);
        end
        step();
        bus.ins_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_valid(ok);
            vectors++;
            if ({ok, bus.ddr1_st_addr, bus.ddr1_burst} !== {1'b1, q[i][31:0], 16'(i + 1)}) begin
                miscompares++;
                $display("FAIL fifo_order[%0d]: got v=%b addr=%h burst=%0d want 1/%h/%0d", i, ok,
                         bus.ddr1_st_addr, bus.ddr1_burst, q[i][31:0], i + 1);
            end
            serve(1, 1'b0, ok, bad, drop);
        end
    endtask

    task automatic test_rx_stall();
        bit ok, bad, drop, conf_dropped, early;
        int hi = 0;
        bus.rx_ins_ready = 1'b0;
        bus.ddr1_conf_ready = 1'b1;
        push(mk(4'b0100, 12'h0, 8'd7, 32'h3000), ok);
        push(mk(4'b0100, 12'h0, 8'd7, 32'h3100), ok);
        wait_valid(ok);
        conf_dropped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rx_ins_valid) hi++;
            if (i == 1) conf_dropped = !bus.ddr1_conf_valid;
            bus.ddr1_done = (i == 4);
            step();
        end
        vectors++;
        if ({conf_dropped, hi} !== {1'b1, 32'd10}) begin
            miscompares++; $display("FAIL rx_stall: conf_dropped=%b rx_high=%0d want 1/10", conf_dropped, hi);
        end
        bus.rx_ins_ready = 1'b1;
        bus.ddr1_done = 1'b1;
        step();
        bus.ddr1_done = 1'b0;
        bus.ddr2_done = 1'b1;
        early = 1'b0;
        repeat (4) begin
            step();
            bus.ddr2_done = 1'b0;
            early |= bus.ddr1_conf_valid | bus.rx_ins_valid;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++; $display("FAIL wait_hold: stray done retired early, got %b want 0", early);
        end
        pulse_done(1);
        exp_retired++;
        wait_valid(ok);
        vectors++;
        if ({ok, bus.ddr1_st_addr} !== {1'b1, 32'h3100}) begin
            miscompares++; $display("FAIL rx_next: got v=%b addr=%h want 1/3100", ok, bus.ddr1_st_addr);
        end
        serve(1, 1'b0, ok, bad, drop);
    endtask

    task automatic test_no_channel();
        logic [63:0] w;
        bit ok, bad, drop;
        w = mk(4'b1000, 12'habc, 8'h05, 32'hdead_0000);
        push(w, ok);
        wait_valid(ok);
        vectors++;
        if ({bus.rx_ins_valid, bus.ddr1_conf_valid, bus.ddr2_conf_valid, bus.rx_ins, bus.ddr1_st_addr}
            !== {3'b100, w, 32'h3100}) begin
            miscompares++;
            $display("FAIL nochan: got rxv=%b v1=%b v2=%b rx=%h a1=%h want 1/0/0/%h/3100", bus.rx_ins_valid,
                     bus.ddr1_conf_valid, bus.ddr2_conf_valid, bus.rx_ins, bus.ddr1_st_addr, w);
        end
        serve(0, 1'b0, ok, bad, drop);
        push(mk(4'b0100, 12'h0, 8'd1, 32'h4000), ok);
        wait_valid(ok);
        vectors++;
        if ({ok, bad, bus.ddr1_st_addr} !== {2'b10, 32'h4000}) begin
            miscompares++; $display("FAIL nochan_retire: got v=%b stray=%b addr=%h want 1/0/4000", ok, bad, bus.ddr1_st_addr);
        end
        serve(1, 1'b0, ok, bad, drop);
    endtask

    task automatic test_random();
        logic [63:0] w;
        logic [95:0] exp_desc, got;
        int ch;
        bit ok, bad, drop;
        for (int i = 0; i < 30; i++) begin
            bus.in_img_width  = 8'($urandom);
            bus.out_img_width = 8'($urandom);
            bus.in_ch_seg     = 4'($urandom);
            bus.out_ch_seg    = 4'($urandom);
            w = mk(4'($urandom_range(0, 15)), 12'($urandom), 8'($urandom), $urandom)
                | {2'($urandom), 4'b0000, 6'($urandom), 52'd0};
            model(w, ch, exp_desc);
            push(w, ok);
            wait_valid(ok);
            got = (ch == 2) ? {bus.ddr2_st_addr, bus.ddr2_burst, bus.ddr2_step, bus.ddr2_burst_num}
                            : {bus.ddr1_st_addr, bus.ddr1_burst, bus.ddr1_step, bus.ddr1_burst_num};
            vectors++;
            if (ch != 0 && got !== exp_desc) begin
                miscompares++; $display("FAIL rnd_desc[%0d] ch%0d: got %h want %h", i, ch, got, exp_desc);
            end
            vectors++;
            if ({ok, bus.rx_ins} !== {1'b1, w}) begin
                miscompares++; $display("FAIL rnd_rx[%0d]: got v=%b rx=%h want 1/%h", i, ok, bus.rx_ins, w);
            end
            serve(ch, 1'b1, ok, bad, drop);
            vectors++;
            if ({ok, bad, drop} !== 3'b100) begin
                miscompares++;
                $display("FAIL rnd_hs[%0d]: done/stray/dropped got %b%b%b want 100", i, ok, bad, drop);
            end
        end
`ifdef DDR_RD_STAT_EN
        vectors++;
        if (stat_retired !== 16'(exp_retired)) begin
            miscompares++; $display("FAIL stat_retired: got %0d want %0d", stat_retired, exp_retired);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok, stray;
        for (int i = 0; i < 4; i++) push(mk(4'b0100, 12'h0, 8'd3, 32'h5000 + 32'(i)), ok);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.ddr1_conf_valid, bus.ddr2_conf_valid, bus.rx_ins_valid, bus.ins_ready, bus.ddr1_st_addr}
            !== {4'b0001, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_mid: v1/v2/rx/rdy=%b%b%b%b addr=%h want 0001/0", bus.ddr1_conf_valid,
                     bus.ddr2_conf_valid, bus.rx_ins_valid, bus.ins_ready, bus.ddr1_st_addr);
        end
        bus.ddr1_done = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            step();
            bus.ddr1_done = 1'b0;
            stray |= bus.ddr1_conf_valid | bus.ddr2_conf_valid | bus.rx_ins_valid;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++; $display("FAIL rst_flush: flushed entry dispatched, got %b want 0", stray);
        end
`ifdef DDR_RD_STAT_EN
        vectors++;
        if (stat_retired !== 16'd0) begin
            miscompares++; $display("FAIL stat_reset: got %0d want 0", stat_retired);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.in_img_width = 8'd0;  bus.out_img_width = 8'd0;
        bus.in_ch_seg = 4'd0;     bus.out_ch_seg = 4'd0;
        bus.ins_valid = 1'b0;     bus.ins = '0;
        bus.rx_ins_ready = 1'b1;
        bus.ddr1_conf_ready = 1'b1; bus.ddr1_done = 1'b0;
        bus.ddr2_conf_ready = 1'b1; bus.ddr2_done = 1'b0;
        test_reset();
        test_ch1_linear();
        test_conv();
        test_ch2();
        test_queue_full();
        test_rx_stall();
        test_no_channel();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
